mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Sequences and shares the single memory interface (MAR/MDR, EN/RW, MFC handshake) between the fetch FSM and the execute unit's load/store path.
- Grants the bus to one requester at a time and runs the memory access to MFC.
- Returns a one-cycle done pulse to the owner, or a bus error if MFC never arrives.
- Sits between the control unit and the memory controller, above the fetch and execute FSMs.

Parameters:
- TIMEOUT_CYC, 15: cycles in WAIT_MFC without MFC before the access is aborted (1..2^TW-1).
- TW, 4: width of the timeout counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-low reset
- fetch_req  input  1  fetch FSM requests an instruction read
- exec_req  input  1  execute unit requests a data access
- exec_rw  input  1  execute access type: 1=read, 0=write
- MFC  input  1  memory function complete from memory
- fetch_gnt  output  1  fetch owns bus (drives PC onto bus / MARin)
- exec_gnt  output  1  execute owns bus
- EN  output  1  memory enable
- RW  output  1  memory direction, 1=read, 0=write
- fetch_done  output  1  one-cycle pulse, fetch access complete
- exec_done  output  1  one-cycle pulse, execute access complete
- bus_err  output  1  one-cycle pulse, access timed out
- owner  output  2  00 none, 01 fetch, 10 exec

Behaviour:
- Reset: rst=0 sampled on a rising clk -> state IDLE, timeout counter 0, last_owner=fetch.
  - All outputs are 0 during and after reset; owner=00.
  - Reset mid-access aborts at once, with no done or err pulse.
- States: IDLE, GRANT, WAIT_MFC, DONE, ERR. Outputs are Moore, decoded from state and latched owner/rw.
- IDLE:
  - All outputs 0. Requests are sampled here only.
  - Only one req high -> latch that owner; go to GRANT.
  - Both high -> grant the requester that is not last_owner (alternating fairness).
  - exec_rw is latched with the grant. For fetch, the latched rw=1.
  - No req -> stay in IDLE.
- GRANT (1 cycle):
  - Owner's gnt=1, owner code valid, EN=0. The owner drives the address and MARin this cycle.
  - Counter cleared. Next state is WAIT_MFC unconditionally.
- WAIT_MFC:
  - gnt held, EN=1, RW=latched rw. Counter increments each cycle.
  - MFC=1 -> DONE. MFC takes priority over timeout if both occur in the same cycle.
  - Counter == TIMEOUT_CYC-1 and MFC=0 -> ERR.
- DONE (1 cycle):
  - gnt held, EN=0. Owner's done=1; the owner latches MDR/IR this cycle.
  - last_owner <= owner. Next state is IDLE.
- ERR (1 cycle):
  - bus_err=1, gnt held, EN=0, no done pulse.
  - last_owner <= owner. Next state is IDLE.
- MFC outside WAIT_MFC is ignored.
- A req dropped after the grant does not abort the access. The access runs to DONE/ERR.
- A req held high after done is re-arbitrated in IDLE.
- Minimum access is 4 cycles: IDLE, GRANT, WAIT_MFC, DONE (MFC on the first WAIT cycle). Back-to-back accesses are therefore 4 cycles apart.
- At most one of fetch_gnt/exec_gnt is high. EN=1 only in WAIT_MFC. done and err are mutually exclusive.
- Counter is TW bits and saturates, never wraps; it is cleared in GRANT.

Test Plan:
- Reset: hold rst=0 for 2 cycles with fetch_req=exec_req=1 and MFC=1 -> all outputs 0 and owner=00 throughout. Release -> first grant is exec, because last_owner=fetch.
- Single fetch: fetch_req=1, MFC=1 two cycles after GRANT -> expected sequence:
  - fetch_gnt=1 from cycle 1.
  - EN=RW=1 for 2 cycles.
  - fetch_done=1 on cycle 4 only.
  - owner=01 throughout; IDLE on cycle 5.
- Exec write: exec_req=1, exec_rw=0, MFC on the first WAIT cycle -> EN=1 and RW=0 for 1 cycle, then exec_done pulse. fetch_gnt stays 0 throughout.
- Contention: both reqs held high for 3 accesses with immediate MFC -> owners alternate exec, fetch, exec, with done pulses 4 cycles apart.
- Timeout: fetch_req=1, MFC=0 -> EN=1 for exactly 15 cycles, then bus_err=1 for one cycle and no fetch_done, then return to IDLE. Same-cycle MFC on the 15th WAIT cycle -> fetch_done instead of bus_err.
- Reset mid-access: assert rst=0 during cycle 3 of WAIT_MFC -> next edge gives EN=0, gnt=0, no done/err. Release with fetch_req=1 -> fresh GRANT.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: request/grant handshake between fetch/execute and the arbiter,
// plus the memory-side EN/RW/MFC strobes.
interface mem_bus_arbiter_if;
    logic       fetch_req;
    logic       exec_req;
    logic       exec_rw;
    logic       MFC;
    logic       fetch_gnt;
    logic       exec_gnt;
    logic       EN;
    logic       RW;
    logic       fetch_done;
    logic       exec_done;
    logic       bus_err;
    logic [1:0] owner;
    modport master (
        input  fetch_req, exec_req, exec_rw, MFC,
        output fetch_gnt, exec_gnt, EN, RW, fetch_done, exec_done, bus_err, owner
    );
    modport slave (
        output fetch_req, exec_req, exec_rw, MFC,
        input  fetch_gnt, exec_gnt, EN, RW, fetch_done, exec_done, bus_err, owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single memory port between fetch and execute,
// runs each access to MFC or aborts it with a bus error on timeout.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYC = 15,
    parameter int TW          = 4
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, GRANT, WAIT_MFC, DONE, ERR} state_t;
    state_t        r_state;
    state_t        w_next;
    logic          r_exec;
    logic          r_rw;
    logic          r_last_exec;
    logic [TW-1:0] r_cnt;
    logic          w_any_req;
    logic          w_pick_exec;
    logic          w_timeout;
    logic          w_busy;
    assign w_any_req   = bus.fetch_req | bus.exec_req;
    // on contention the requester that did not own the previous access wins
    assign w_pick_exec = bus.exec_req & (~bus.fetch_req | ~r_last_exec);
    assign w_timeout   = r_cnt == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_any_req ? GRANT : IDLE;
            GRANT:    w_next = WAIT_MFC;
            WAIT_MFC: w_next = bus.MFC ? DONE : (w_timeout ? ERR : WAIT_MFC);
            default:  w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exec      <= 1'b0;
            r_rw        <= 1'b0;
            r_last_exec <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_exec <= w_pick_exec;
                r_rw   <= w_pick_exec ? bus.exec_rw : 1'b1;
            end
            // saturating so a long wait can never wrap past the timeout compare
            if (r_state == GRANT)                        r_cnt <= '0;
            else if (r_state == WAIT_MFC && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            if (r_state == DONE || r_state == ERR) r_last_exec <= r_exec;
        end
    end
    always_comb begin
        w_busy         = r_state != IDLE;
        bus.fetch_gnt  = w_busy & ~r_exec;
        bus.exec_gnt   = w_busy & r_exec;
        bus.EN         = r_state == WAIT_MFC;
        bus.RW         = (r_state == WAIT_MFC) & r_rw;
        bus.fetch_done = (r_state == DONE) & ~r_exec;
        bus.exec_done  = (r_state == DONE) & r_exec;
        bus.bus_err    = r_state == ERR;
        bus.owner      = w_busy ? (r_exec ? 2'b10 : 2'b01) : 2'b00;
    end
endmodule
